// File: rtl/rv32_mem_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
package rv32_mem_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Owner encoding of the outstanding transaction.
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  localparam int DEF_MEM_LAT         = 2;
  localparam int DEF_MAX_DATA_STREAK = 4;

  // Snapshot of the arbiter FSM, exported for observation.
  typedef struct packed {
    state_t state;
    logic   owner;
    logic   is_write;
  } arb_dbg_t;

endpackage

// File: rtl/mem_arb_picker.sv
// Combinational requester selection: data first, fetch once the streak limit is hit.
module mem_arb_picker #(
  parameter int STREAK_W        = 3,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                if_req_i,
  input  logic                d_req_i,
  input  logic                halt_i,
  input  logic [STREAK_W-1:0] streak_i,
  output logic                sel_if_o,
  output logic                sel_d_o
);

  logic fetch_due;

  // Fetch is owed a turn once data has won MAX_DATA_STREAK times while it waited.
  always_comb begin
    fetch_due = if_req_i && (streak_i == STREAK_W'(MAX_DATA_STREAK));
    sel_if_o  = !halt_i && if_req_i && (!d_req_i || fetch_due);
    sel_d_o   = !halt_i && d_req_i && !fetch_due;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// One transaction in flight; read data returns MEM_LAT cycles after issue.
//
// Handshake: a requester raises req with addr/we/wdata and holds them stable
// until the cycle its gnt is 1; that cycle is the issue cycle and the access
// is on the mem_* outputs combinationally. Dropping req before gnt withdraws
// the request. Exactly MEM_LAT cycles after gnt the requester sees a one-cycle
// rvalid carrying read data (or 0 for a store acknowledge).
module mem_port_arbiter
  import rv32_mem_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MEM_LAT         = DEF_MEM_LAT,
  parameter int MAX_DATA_STREAK = DEF_MAX_DATA_STREAK
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                halt,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W/8-1:0] d_we,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output arb_dbg_t            dbg_state
);

  localparam int STREAK_W = (MAX_DATA_STREAK < 1) ? 1 : $clog2(MAX_DATA_STREAK + 1);
  localparam int LAT_W    = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT);

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                is_write_q, is_write_d;
  logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
  logic [STREAK_W-1:0] streak_q, streak_d;

  logic can_issue;
  logic sel_if;
  logic sel_d;
  logic done;

  // Issue is only possible from IDLE, and never while reset is asserted so
  // that every output reads 0 the moment rst rises.
  assign can_issue = (state_q == ST_IDLE) && !rst;
  assign done      = (state_q == ST_WAIT) && (lat_cnt_q == '0);

  mem_arb_picker #(
    .STREAK_W        (STREAK_W),
    .MAX_DATA_STREAK (MAX_DATA_STREAK)
  ) u_picker (
    .if_req_i (if_req),
    .d_req_i  (d_req),
    .halt_i   (halt || !can_issue),
    .streak_i (streak_q),
    .sel_if_o (sel_if),
    .sel_d_o  (sel_d)
  );

  // State register; reset drops any in-flight transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_IF;
      is_write_q <= 1'b0;
      lat_cnt_q  <= '0;
      streak_q   <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      is_write_q <= is_write_d;
      lat_cnt_q  <= lat_cnt_d;
      streak_q   <= streak_d;
    end
  end

  // Next-state: latch the winner on issue, count down the memory latency.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    is_write_d = is_write_q;
    lat_cnt_d  = lat_cnt_q;
    streak_d   = streak_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_if || sel_d) begin
          state_d    = ST_WAIT;
          lat_cnt_d  = LAT_W'(MEM_LAT - 1);
          owner_d    = sel_d ? OWN_D : OWN_IF;
          is_write_d = sel_d && (d_we != '0);
        end
      end
      ST_WAIT: begin
        if (lat_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Streak counts data wins only while fetch is actually waiting.
    if (sel_d) begin
      if (!if_req) begin
        streak_d = '0;
      end else if (streak_q != STREAK_W'(MAX_DATA_STREAK)) begin
        streak_d = streak_q + 1'b1;
      end
    end else if (sel_if) begin
      streak_d = '0;
    end
  end

  // Outputs: memory strobes and grants on issue, response to the owner on completion.
  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if_rvalid = 1'b0;
    if_rdata  = '0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    if (sel_if) begin
      if_gnt   = 1'b1;
      mem_en   = 1'b1;
      mem_addr = if_addr;
    end else if (sel_d) begin
      d_gnt     = 1'b1;
      mem_en    = 1'b1;
      mem_addr  = d_addr;
      mem_we    = d_we;
      mem_wdata = d_wdata;
    end
    if (done) begin
      if (owner_q == OWN_IF) begin
        if_rvalid = 1'b1;
        if_rdata  = is_write_q ? '0 : mem_rdata;
      end else begin
        d_rvalid = 1'b1;
        d_rdata  = is_write_q ? '0 : mem_rdata;
      end
    end
    busy      = (state_q != ST_IDLE) || sel_if || sel_d;
    dbg_state = '{state: state_q, owner: owner_q, is_write: is_write_q};
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port unified memory between the instruction-fetch requester and the load/store requester of the multicycle RV32 core. It sits between the control FSM/datapath and the memory macro. It issues one transaction at a time and returns read data after a fixed memory latency. Data accesses have priority, and a streak limit guarantees that fetch is never starved. A halt input blocks new grants.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; a multiple of 8
MEM_LAT, 2, cycles from issue to mem_rdata valid; must be at least 1
MAX_DATA_STREAK, 4, consecutive data grants allowed while if_req is pending

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
halt  in  1  1 = block new grants
if_req  in  1  fetch request; held until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  fetch issued this cycle
if_rvalid  out  1  fetch data valid
if_rdata  out  DATA_W  fetch data
d_req  in  1  data request; held until d_gnt
d_addr  in  ADDR_W  data address
d_we  in  DATA_W/8  byte write enables; 0 = read
d_wdata  in  DATA_W  store data
d_gnt  out  1  data access issued this cycle
d_rvalid  out  1  load data valid, or store acknowledge
d_rdata  out  DATA_W  load data; 0 for a store
mem_en  out  1  memory access strobe
mem_we  out  DATA_W/8  memory byte write enables
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after issue
busy  out  1  state != IDLE, or issuing this cycle

Behaviour:
- States:
  - IDLE: no transaction outstanding.
  - WAIT: one transaction outstanding.
  - Registers: owner (IF/D), is_write, lat_cnt, streak.
- Reset (async, any state):
  - state=IDLE, lat_cnt=0, streak=0, owner=IF.
  - Every output is 0 immediately.
  - An in-flight transaction is dropped; no rvalid is produced for it.
- Issue, in IDLE with halt=0 and (if_req or d_req):
  - Selection:
    - Data wins, unless if_req=1 and streak==MAX_DATA_STREAK; then fetch wins.
  - Same cycle (combinational):
    - mem_en=1.
    - mem_addr, mem_we, mem_wdata come from the selected requester.
    - A fetch drives mem_we=0 and mem_wdata=0.
    - The matching gnt=1.
  - On the next edge:
    - state→WAIT, lat_cnt=MEM_LAT-1.
    - owner and is_write are latched.
- Streak counter:
  - Data grant with if_req=1: streak+1, saturating.
  - Data grant with if_req=0: streak=0.
  - Fetch grant: streak=0.
- IDLE with halt=1 or no requests:
  - All strobes are 0.
  - The mem_addr/mem_wdata/mem_we outputs are driven 0.
- WAIT:
  - lat_cnt decrements each cycle.
  - In the cycle with lat_cnt==0 (issue cycle + MEM_LAT):
    - The owner's rvalid=1.
    - rdata = mem_rdata for a read, 0 for a write.
    - The next state is IDLE.
  - No grants are given in WAIT. Issue-to-issue spacing is at least MEM_LAT+1.
- halt:
  - Has no effect on an outstanding transaction; it always completes.
  - Only blocks issue in IDLE.
- The non-owner's rvalid and rdata are always 0. gnt and rvalid are never both 1 for the same requester.
- Requester contract:
  - req/addr/we/wdata are held stable until gnt.
  - Dropping req before gnt cancels the request; no error is raised.

Decomposition:
- Package rv32_mem_pkg:
  - state enum {ST_IDLE, ST_WAIT}.
  - Owner encoding OWN_IF=0, OWN_D=1.
  - Default MEM_LAT and MAX_DATA_STREAK constants.
- One natural sub-module: mem_arb_picker.
  - Combinational.
  - Inputs: if_req, d_req, halt, streak.
  - Outputs: sel_if, sel_d.

Test Plan (MEM_LAT=2, MAX_DATA_STREAK=4):
1. if_req=1, if_addr=0x100 in cycle 1; memory returns 0xDEADBEEF → cycle 1: if_gnt=1, mem_en=1, mem_addr=0x100, mem_we=0. Cycle 3: if_rvalid=1, if_rdata=0xDEADBEEF. busy=1 in cycles 1-3.
2. if_req and d_req (read, 0x200) both raised in cycle 1 → d_gnt in cycle 1, d_rvalid in cycle 3. if_gnt in cycle 4, if_rvalid in cycle 6.
3. Store: d_we=4'b1111, d_addr=0x40, d_wdata=0xA5A5A5A5 → mem_we=4'b1111, mem_wdata=0xA5A5A5A5 in the issue cycle. d_rvalid=1 with d_rdata=0 two cycles later.
4. d_req and if_req held high continuously → grant order D,D,D,D,IF,D,D,D,D,IF; a grant every 3 cycles.
5. halt=1 in IDLE with both requests pending → no gnt, mem_en=0 for 10 cycles. halt raised in WAIT → rvalid still delivered and no new issue. halt=0 → issue on the same cycle.
6. rst pulsed in the first WAIT cycle of a fetch → all outputs 0 at once and no if_rvalid. After release, a d_req read issues normally with streak=0.
